// File: rtl/instr_fetch_unit_pkg.sv
// Shared ISA definitions for the oc8 fetch path: opcode constants, the
// fetch FSM state type and the instruction length type.
package oc8_isa_pkg;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_ADD_IMM = 8'h01;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;

  // Instruction length in bytes (1..3); 0 only appears as the reset value.
  typedef logic [1:0] ilen_t;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    HOLD     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: ROM read port, instruction handoff to the
// execute stage, and the PC redirect path from execute.
//   master : the fetch unit (drives mem_addr and instr_*)
//   slave  : ROM + execute side (drives mem_data, instr_ready, redirect_*)
interface instr_fetch_unit_if;
  import oc8_isa_pkg::*;

  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [15:0] instr_operand;
  ilen_t       instr_len;
  logic [15:0] instr_pc;
  logic        instr_illegal;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  modport master (
    output mem_addr, instr_valid, instr_opcode, instr_operand,
           instr_len, instr_pc, instr_illegal,
    input  mem_data, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_addr, instr_valid, instr_opcode, instr_operand,
           instr_len, instr_pc, instr_illegal,
    output mem_data, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_len_decode.sv
// Combinational opcode decoder: opcode -> instruction length and illegal flag.
//   i_opcode  : opcode byte
//   o_len     : length in bytes (1..3)
//   o_illegal : opcode not in the ISA table (reported as a 1-byte instruction)
module instr_len_decode
  import oc8_isa_pkg::*;
(
  input  logic [7:0] i_opcode,
  output ilen_t      o_len,
  output logic       o_illegal
);
  always_comb begin
    o_len     = 2'd1;
    o_illegal = 1'b1;
    case (i_opcode)
      OP_LDA_IMM, OP_ADD_IMM: begin o_len = 2'd2; o_illegal = 1'b0; end
      OP_JMP_ABS:             begin o_len = 2'd3; o_illegal = 1'b0; end
      default:                ;
    endcase
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Byte-serial instruction fetch: reads one ROM byte per cycle at the PC,
// assembles opcode + operand bytes and presents the instruction to execute
// with a valid/ready handshake. Redirects from execute reload the PC.
//   clk, rst : clock, synchronous active-high reset
//   bus      : instr_fetch_unit_if.master (ROM port, instr handoff, redirect)
module instr_fetch_unit
  import oc8_isa_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  instr_fetch_unit_if.master bus
);
  fetch_state_t r_state, w_state_nxt;
  logic [15:0]  r_pc;
  // Assembly registers: hold the instruction being fetched.
  logic [7:0]   r_op;
  logic [15:0]  r_op_pc;
  logic [7:0]   r_lo;
  ilen_t        r_len;
  logic         r_ill;
  // Output registers: only reloaded on entry to HOLD so the handoff stays
  // stable while later bytes of the next instruction are being assembled.
  logic         r_valid;
  logic [7:0]   r_o_opcode;
  logic [15:0]  r_o_operand;
  ilen_t        r_o_len;
  logic [15:0]  r_o_pc;
  logic         r_o_ill;

  ilen_t        w_dec_len;
  logic         w_dec_ill;
  logic         w_consume;
  logic         w_load_out;
  logic [7:0]   w_out_opcode;
  logic [15:0]  w_out_operand;
  ilen_t        w_out_len;
  logic [15:0]  w_out_pc;
  logic         w_out_ill;

  instr_len_decode u_dec (
    .i_opcode  (bus.mem_data),
    .o_len     (w_dec_len),
    .o_illegal (w_dec_ill)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_consume   = 1'b0;
    w_load_out  = 1'b0;
    unique case (r_state)
      FETCH_OP: begin
        w_consume = 1'b1;
        if (w_dec_len == 2'd1) begin w_state_nxt = HOLD; w_load_out = 1'b1; end
        else                          w_state_nxt = FETCH_LO;
      end
      FETCH_LO: begin
        w_consume = 1'b1;
        if (r_len == 2'd2) begin w_state_nxt = HOLD; w_load_out = 1'b1; end
        else                      w_state_nxt = FETCH_HI;
      end
      FETCH_HI: begin
        w_consume   = 1'b1;
        w_state_nxt = HOLD;
        w_load_out  = 1'b1;
      end
      HOLD: if (bus.instr_ready) w_state_nxt = FETCH_OP;
    endcase
    // Redirect overrides everything: partial bytes are dropped. In HOLD the
    // handshake (if ready) still completes, since HOLD leaves to FETCH_OP anyway.
    if (bus.redirect_valid) begin
      w_state_nxt = FETCH_OP;
      w_consume   = 1'b0;
      w_load_out  = 1'b0;
    end
  end

  // The final byte arrives combinationally, so the completed instruction is
  // formed from the assembly registers plus the current mem_data.
  always_comb begin
    w_out_opcode  = r_op;
    w_out_len     = r_len;
    w_out_ill     = r_ill;
    w_out_pc      = r_op_pc;
    w_out_operand = {bus.mem_data, r_lo};
    if (r_state == FETCH_OP) begin
      w_out_opcode  = bus.mem_data;
      w_out_len     = w_dec_len;
      w_out_ill     = w_dec_ill;
      w_out_pc      = r_pc;
      w_out_operand = 16'h0000;
    end else if (r_state == FETCH_LO) begin
      w_out_operand = {8'h00, bus.mem_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FETCH_OP;
      r_pc        <= RESET_PC;
      r_op        <= 8'h00;
      r_op_pc     <= 16'h0000;
      r_lo        <= 8'h00;
      r_len       <= 2'd0;
      r_ill       <= 1'b0;
      r_valid     <= 1'b0;
      r_o_opcode  <= 8'h00;
      r_o_operand <= 16'h0000;
      r_o_len     <= 2'd0;
      r_o_pc      <= 16'h0000;
      r_o_ill     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= (w_state_nxt == HOLD);
      if (bus.redirect_valid) r_pc <= bus.redirect_pc;
      else if (w_consume)     r_pc <= r_pc + 16'd1;
      if (w_consume && r_state == FETCH_OP) begin
        r_op    <= bus.mem_data;
        r_op_pc <= r_pc;
        r_len   <= w_dec_len;
        r_ill   <= w_dec_ill;
        r_lo    <= 8'h00;
      end
      if (w_consume && r_state == FETCH_LO) r_lo <= bus.mem_data;
      if (w_load_out) begin
        r_o_opcode  <= w_out_opcode;
        r_o_operand <= w_out_operand;
        r_o_len     <= w_out_len;
        r_o_pc      <= w_out_pc;
        r_o_ill     <= w_out_ill;
      end
    end
  end

  assign bus.mem_addr      = r_pc;
  assign bus.instr_valid   = r_valid;
  assign bus.instr_opcode  = r_o_opcode;
  assign bus.instr_operand = r_o_operand;
  assign bus.instr_len     = r_o_len;
  assign bus.instr_pc      = r_o_pc;
  assign bus.instr_illegal = r_o_ill;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  logic clk, rst;
  logic [7:0] rom [0:65535];
  int total = 0;
  int bad   = 0;

  instr_fetch_unit_if if1 ();
  instr_fetch_unit_if if2 ();

  instr_fetch_unit #(.RESET_PC(16'h0000)) dut (.clk(clk), .rst(rst), .bus(if1.master));
  instr_fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  assign if1.mem_data = rom[if1.mem_addr];
  // Second instance sees a tiny ROM for the wrap case.
  assign if2.mem_data = (if2.mem_addr == 16'hFFFF) ? 8'hA9 :
                        (if2.mem_addr == 16'h0000) ? 8'h7E : 8'hEA;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: decode the instruction starting at pc straight from the ROM image.
  function automatic void ref_instr(input logic [15:0] pc, output logic [7:0] op,
                                    output logic [15:0] opd, output int len, output logic ill);
    logic [15:0] p1, p2;
    p1 = pc + 16'd1;
    p2 = pc + 16'd2;
    op = rom[pc];
    if (op == 8'hA9 || op == 8'h01) len = 2;
    else if (op == 8'h4C)           len = 3;
    else                            len = 1;
    ill = (len == 1);
    opd = (len == 1) ? 16'h0000 : (len == 2) ? {8'h00, rom[p1]} : {rom[p2], rom[p1]};
  endfunction

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [15:0] opd,
                           input int len, input logic [15:0] pc, input logic ill);
    chk({tag, "_valid"}, {31'd0, if1.instr_valid}, 32'd1);
    chk({tag, "_op"},    {24'd0, if1.instr_opcode}, {24'd0, op});
    chk({tag, "_opd"},   {16'd0, if1.instr_operand}, {16'd0, opd});
    chk({tag, "_len"},   {30'd0, if1.instr_len}, len);
    chk({tag, "_pc"},    {16'd0, if1.instr_pc}, {16'd0, pc});
    chk({tag, "_ill"},   {31'd0, if1.instr_illegal}, {31'd0, ill});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'd0, if1.instr_valid}, 32'd0);
    chk({tag, "_op"},    {24'd0, if1.instr_opcode}, 32'd0);
    chk({tag, "_opd"},   {16'd0, if1.instr_operand}, 32'd0);
    chk({tag, "_len"},   {30'd0, if1.instr_len}, 32'd0);
    chk({tag, "_pc"},    {16'd0, if1.instr_pc}, 32'd0);
    chk({tag, "_ill"},   {31'd0, if1.instr_illegal}, 32'd0);
    chk({tag, "_addr"},  {16'd0, if1.mem_addr}, 32'd0);
  endtask

  // First step carries whatever handshake/redirect is set up; len idle cycles
  // are expected before the instruction shows up.
  task automatic expect_next(input string tag, input int len, input logic [7:0] op,
                             input logic [15:0] opd, input logic [15:0] pc, input logic ill);
    for (int i = 0; i < len; i++) begin
      step();
      if1.redirect_valid = 1'b0;
      chk({tag, "_idle"}, {31'd0, if1.instr_valid}, 32'd0);
    end
    step();
    chk_instr(tag, op, opd, len, pc, ill);
  endtask

  initial begin
    logic [7:0]  m_op;
    logic [15:0] m_opd, m_pc;
    int          m_len, waitc;
    logic        m_ill, seen, rdy, rdr;
    logic [15:0] tgt;

    for (int i = 0; i < 65536; i++) rom[i] = 8'hEA;
    rom[0] = 8'hA9; rom[1] = 8'h00; rom[2] = 8'h01; rom[3] = 8'h01;
    rom[4] = 8'h4C; rom[5] = 8'h02; rom[6] = 8'h00; rom[16'h10] = 8'hFF;

    rst = 1'b1;
    if1.instr_ready = 1'b0; if1.redirect_valid = 1'b0; if1.redirect_pc = 16'h0000;
    if2.instr_ready = 1'b0; if2.redirect_valid = 1'b0; if2.redirect_pc = 16'h0000;
    @(negedge clk);
    step();
    chk_reset("rst");

    // LDA arrives two cycles after release; hold it with ready low.
    rst = 1'b0;
    step();
    chk("lda_lat", {31'd0, if1.instr_valid}, 32'd0);
    step();
    chk_instr("lda", 8'hA9, 16'h0000, 2, 16'h0000, 1'b0);
    chk("wrap_valid", {31'd0, if2.instr_valid}, 32'd1);
    chk("wrap_opd",   {16'd0, if2.instr_operand}, 32'h007E);
    chk("wrap_pc",    {16'd0, if2.instr_pc}, 32'hFFFF);
    chk("wrap_addr",  {16'd0, if2.mem_addr}, 32'h0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_instr("lda_hold", 8'hA9, 16'h0000, 2, 16'h0000, 1'b0);
      chk("lda_hold_addr", {16'd0, if1.mem_addr}, 32'h0002);
    end

    if1.instr_ready = 1'b1;
    expect_next("add", 2, 8'h01, 16'h0001, 16'h0002, 1'b0);
    expect_next("jmp", 3, 8'h4C, 16'h0002, 16'h0004, 1'b0);

    // Execute services JMP 0002 by redirecting in the same cycle as ready.
    for (int k = 0; k < 3; k++) begin
      if1.redirect_valid = 1'b1; if1.redirect_pc = 16'h0002;
      expect_next("loop_add", 2, 8'h01, 16'h0001, 16'h0002, 1'b0);
      expect_next("loop_jmp", 3, 8'h4C, 16'h0002, 16'h0004, 1'b0);
    end

    // Redirect while the JMP is in FETCH_LO.
    if1.redirect_valid = 1'b1; if1.redirect_pc = 16'h0002;
    expect_next("pre_add", 2, 8'h01, 16'h0001, 16'h0002, 1'b0);
    step();
    chk("jop_addr", {16'd0, if1.mem_addr}, 32'h0004);
    step();
    chk("jlo_addr", {16'd0, if1.mem_addr}, 32'h0005);
    if1.redirect_valid = 1'b1; if1.redirect_pc = 16'h0000;
    expect_next("flush_lda", 2, 8'hA9, 16'h0000, 16'h0000, 1'b0);

    // Illegal opcode.
    if1.redirect_valid = 1'b1; if1.redirect_pc = 16'h0010;
    expect_next("ill", 1, 8'hFF, 16'h0000, 16'h0010, 1'b1);
    chk("ill_addr", {16'd0, if1.mem_addr}, 32'h0011);
    if1.instr_ready = 1'b0;
    step();
    chk("ill_hold_valid", {31'd0, if1.instr_valid}, 32'd1);
    chk("ill_hold_addr", {16'd0, if1.mem_addr}, 32'h0011);

    // Redirect without ready drops the held instruction; then reset in FETCH_HI
    // with a simultaneous redirect (reset wins).
    if1.redirect_valid = 1'b1; if1.redirect_pc = 16'h0004;
    step();
    if1.redirect_valid = 1'b0; if1.instr_ready = 1'b1;
    chk("rdr_nordy_valid", {31'd0, if1.instr_valid}, 32'd0);
    chk("rdr_nordy_addr", {16'd0, if1.mem_addr}, 32'h0004);
    step();
    step();
    chk("jhi_addr", {16'd0, if1.mem_addr}, 32'h0006);
    rst = 1'b1; if1.redirect_valid = 1'b1; if1.redirect_pc = 16'h0010;
    step();
    chk_reset("midrst");
    rst = 1'b0; if1.redirect_valid = 1'b0;
    step();
    chk("midrst_lat", {31'd0, if1.instr_valid}, 32'd0);
    step();
    chk_instr("midrst_lda", 8'hA9, 16'h0000, 2, 16'h0000, 1'b0);

    // Random program, random ready and redirects, checked against the ROM-level model.
    for (int i = 0; i < 65536; i++) begin
      case ($urandom_range(0, 3))
        0:       rom[i] = 8'hA9;
        1:       rom[i] = 8'h01;
        2:       rom[i] = 8'h4C;
        default: rom[i] = 8'($urandom);
      endcase
    end
    rst = 1'b1; if1.redirect_valid = 1'b0;
    step();
    rst = 1'b0;
    m_pc = 16'h0000; waitc = 0; seen = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      ref_instr(m_pc, m_op, m_opd, m_len, m_ill);
      if (if1.instr_valid) begin
        chk_instr("rnd", m_op, m_opd, m_len, m_pc, m_ill);
        chk("rnd_addr", {16'd0, if1.mem_addr}, {16'd0, m_pc + 16'(m_len)});
        if (!seen) chk("rnd_lat", waitc, m_len);
        seen = 1'b1;
      end else begin
        waitc++;
        if (waitc > 3) chk("rnd_stall", waitc, 3);
      end
      rdy = 1'($urandom_range(0, 1));
      rdr = ($urandom_range(0, 9) == 0);
      tgt = 16'($urandom);
      if1.instr_ready = rdy;
      if1.redirect_valid = rdr;
      if1.redirect_pc = tgt;
      if (rdr) begin
        m_pc = tgt; waitc = 0; seen = 1'b0;
      end else if (if1.instr_valid && rdy) begin
        m_pc = m_pc + 16'(m_len); waitc = 0; seen = 1'b0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Bus initiator that reads the program ROM byte by byte.
- Drives a 16-bit byte address and samples the 8-bit ROM data, which is combinational and valid in the same cycle.
- Assembles complete instructions (opcode plus 0–2 operand bytes) and hands each one to the execute stage with a valid/ready handshake.
- Accepts PC redirects (jumps) from execute; sits between the program ROM and the CPU execute/control logic.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset and first fetch address.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
mem_addr  output  16  ROM byte address, equals internal PC register
mem_data  input  8  ROM read data for mem_addr, same-cycle combinational
instr_valid  output  1  assembled instruction available
instr_ready  input  1  execute accepts instruction
instr_opcode  output  8  opcode byte
instr_operand  output  16  operand: {hi,lo} for 3-byte, {8'h00,lo} for 2-byte, 16'h0000 for 1-byte
instr_len  output  2  instruction length in bytes, 1..3
instr_pc  output  16  address of opcode byte
instr_illegal  output  1  opcode not in ISA table
redirect_valid  input  1  load new PC, flush current fetch
redirect_pc  input  16  redirect target

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, state=FETCH_OP, instr_valid=0, instr_opcode=8'h00, instr_operand=16'h0000, instr_len=0, instr_pc=16'h0000, instr_illegal=0. mem_addr follows pc, so it reads RESET_PC in the first cycle after reset. Reset mid-instruction discards all partial state.
- Opcode length table:
  - A9 LDA #imm = 2 bytes
  - 01 ADD #imm = 2 bytes
  - 4C JMP abs = 3 bytes
  - Any other opcode = 1 byte, with instr_illegal=1.
- FSM states: FETCH_OP, FETCH_LO, FETCH_HI, HOLD. One ROM byte is consumed per cycle; pc increments by 1 on every consumed byte.
  - FETCH_OP: latch opcode, instr_pc<=pc, clear operand, pc<=pc+1. Next state is HOLD if len=1, else FETCH_LO.
  - FETCH_LO: operand[7:0]<=mem_data, pc<=pc+1. Next state is HOLD if len=2, else FETCH_HI.
  - FETCH_HI: operand[15:8]<=mem_data, pc<=pc+1. Next state is HOLD.
  - HOLD: instr_valid=1, and all instr_* outputs stay stable. If instr_ready=1, go to FETCH_OP. No prefetch in HOLD; pc stays at the next-instruction address.
- Latency: an N-byte instruction asserts instr_valid exactly N cycles after its FETCH_OP cycle begins. Throughput is one instruction per N+1 cycles with ready held high.
- instr_valid is registered and is 1 only in HOLD. Outputs change only on the transition into HOLD.
- Redirect has priority over everything in every state:
  - Effect: pc<=redirect_pc, state<=FETCH_OP, instr_valid=0 next cycle, partial bytes dropped.
  - Redirect together with instr_ready in HOLD: the handshake completes (instruction consumed) and the redirect is applied.
  - Redirect and rst together: rst wins.
- PC wrap: 16'hFFFF+1=16'h0000, including mid-instruction. An operand straddling the wrap is fetched from 0000.
- mem_addr is driven straight from the pc register; there is no combinational path from mem_data to mem_addr.
- Illegal opcodes are not trapped here; they are passed with the flag set.

Decomposition:
- Package oc8_isa_pkg holds:
  - opcode constants OP_LDA_IMM=8'hA9, OP_ADD_IMM=8'h01, OP_JMP_ABS=8'h4C;
  - the fetch_state_t enum;
  - the 2-bit length type.
- One sub-module, instr_len_decode: combinational opcode -> {len, illegal}, reused later by the disassembler/trace logic.

Test Plan:
- Reset, ROM preloaded with A9 00 01 01 4C 02 00 at 0..6, instr_ready=1:
  - first valid has opcode A9, operand 0000, len 2, pc 0000, at cycle 2 after reset release;
  - next valid has opcode 01, operand 0001, pc 0002;
  - next valid has opcode 4C, operand 0002, len 3, pc 0004.
- Hold instr_ready=0 for 5 cycles on the LDA: instr_valid stays 1, outputs stay constant, mem_addr stays 0002, and the next instruction is not fetched.
- Respond to JMP 0002 with redirect_valid=1, redirect_pc=0002 in the same cycle as ready:
  - next valid is 01/0001 at pc 0002;
  - the loop repeats indefinitely with no spurious valid.
- Assert redirect during FETCH_LO of a JMP, target 0000: the partial JMP is discarded and the next valid is A9 at pc 0000.
- Illegal opcode FF at 0010: valid with len 1, illegal=1, operand 0000; the next fetch is at 0011.
- Wrap case, RESET_PC=FFFF with ROM[FFFF]=A9 and ROM[0000]=7E: valid with operand 007E, pc FFFF, and mem_addr ends at 0001.
- Assert rst for 1 cycle while in FETCH_HI: all outputs return to their reset values and fetch restarts at RESET_PC.
